// File: rtl/srl_shift_column.sv
// One bit-slice of the FIFO storage: a LENGTH-deep shift register with a
// random-access tap. Position 0 holds the newest bit. It has no reset, so
// synthesis can map it onto SRL primitives.
module srl_shift_column #(
    parameter int LOG_DEP = 4
) (
    input  logic               clock,
    input  logic               shift_i,
    input  logic               bit_i,
    input  logic [LOG_DEP-1:0] addr_i,
    output logic               bit_o
);

    localparam int LENGTH = 1 << LOG_DEP;

    logic [LENGTH-1:0] srl_q;

    // Shift the new bit into position 0 whenever a write is accepted.
    always_ff @(posedge clock) begin
        if (shift_i) begin
            srl_q <= {srl_q[LENGTH-2:0], bit_i};
        end
    end

    assign bit_o = srl_q[addr_i];

endmodule

// File: rtl/srl_fifo_stream.sv
// SRL-based first-word-fall-through FIFO with occupancy count, programmable
// almost-full/almost-empty flags, sticky overflow/underflow and a
// synchronous flush. Storage is WIDTH instances of srl_shift_column. The
// top level keeps only the count, the accept logic and the flag decode.
//
// Handshake: a word is popped on a rising edge where read=1 and empty=0.
// The popped word is the one shown on data_out during that cycle.
// A word is pushed on a rising edge where write=1 and either full=0 or a
// pop happens on the same edge. A request that is refused sets the matching
// sticky error flag, unless flush is high in that cycle. Flush and reset
// both override read and write.
module srl_fifo_stream #(
    parameter int WIDTH    = 11,
    parameter int LOG_DEP  = 4,
    parameter int AF_LEVEL = (1 << LOG_DEP) - 2,
    parameter int AE_LEVEL = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [WIDTH-1:0]   data_in,
    input  logic               write,
    input  logic               read,
    input  logic               flush,
    input  logic               clear_err,
    output logic [WIDTH-1:0]   data_out,
    output logic               full,
    output logic               empty,
    output logic               almost_full,
    output logic               almost_empty,
    output logic [LOG_DEP:0]   count,
    output logic               overflow,
    output logic               underflow
);

    localparam int LENGTH = 1 << LOG_DEP;
    localparam int CW     = LOG_DEP + 1;

    localparam logic [CW-1:0] LEN_C = CW'(LENGTH);
    localparam logic [CW-1:0] AF_C  = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C  = CW'(AE_LEVEL);

    if (LOG_DEP < 1 || AF_LEVEL < 1 || AF_LEVEL > LENGTH ||
        AE_LEVEL < 0 || AE_LEVEL > LENGTH - 1) begin : g_bad_params
        $error("srl_fifo_stream: illegal LOG_DEP/AF_LEVEL/AE_LEVEL");
    end

    logic [CW-1:0]      count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;
    logic               rd_ok, wr_ok;
    logic [LOG_DEP-1:0] rd_addr;
    logic [WIDTH-1:0]   rd_word;

    // The flags are decoded straight from the registered count.
    assign empty        = (count_q == '0);
    assign full         = (count_q == LEN_C);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Acceptance uses the current count. A pop frees a slot, so a write
    // into a full FIFO is accepted in the same cycle.
    assign rd_ok = read & ~empty & ~flush & ~reset;
    assign wr_ok = write & (~full | rd_ok) & ~flush & ~reset;

    // The oldest word sits at index count-1. When count==LENGTH the low
    // bits are zero and wrap to LENGTH-1.
    assign rd_addr = count_q[LOG_DEP-1:0] - LOG_DEP'(1);

    for (genvar b = 0; b < WIDTH; b++) begin : g_col
        srl_shift_column #(
            .LOG_DEP (LOG_DEP)
        ) u_col (
            .clock   (clock),
            .shift_i (wr_ok),
            .bit_i   (data_in[b]),
            .addr_i  (rd_addr),
            .bit_o   (rd_word[b])
        );
    end

    assign data_out = empty ? '0 : rd_word;

    // Next occupancy and sticky error flags. A new error event wins over
    // clear_err in the same cycle.
    always_comb begin
        count_d     = count_q;
        overflow_d  = overflow_q & ~clear_err;
        underflow_d = underflow_q & ~clear_err;
        if (flush) begin
            count_d = '0;
        end else begin
            if (wr_ok && !rd_ok) begin
                count_d = count_q + CW'(1);
            end else if (rd_ok && !wr_ok) begin
                count_d = count_q - CW'(1);
            end
            if (write && !wr_ok) begin
                overflow_d = 1'b1;
            end
            if (read && !rd_ok) begin
                underflow_d = 1'b1;
            end
        end
    end

    // Count and error registers. Reset clears them and ignores any request.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: tb/tb_srl_fifo_stream.sv
// Self-checking bench for srl_fifo_stream. The driver pushes predicted pop
// data into exp_q. A negedge monitor pops exp_q whenever the DUT pops a
// word, and it checks count and flags against a queue-based reference.
module tb_srl_fifo_stream;

    localparam int W   = 11;
    localparam int LD  = 4;
    localparam int LEN = 16;
    localparam int AF  = 14;
    localparam int AE  = 1;

    logic          clock = 1'b0;
    logic          reset, write, read, flush, clear_err;
    logic [W-1:0]  data_in;
    logic [W-1:0]  data_out;
    logic          full, empty, almost_full, almost_empty, overflow, underflow;
    logic [LD:0]   count;

    srl_fifo_stream #(
        .WIDTH(W), .LOG_DEP(LD), .AF_LEVEL(AF), .AE_LEVEL(AE)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .data_in      (data_in),
        .write        (write),
        .read         (read),
        .flush        (flush),
        .clear_err    (clear_err),
        .data_out     (data_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    // clock/reset
    always #5 clock = ~clock;

    // reference model and scoreboard
    logic [W-1:0] mq[$];
    logic         m_ovf = 1'b0;
    logic         m_udf = 1'b0;
    logic [W-1:0] exp_q[$];
    int           n_checks = 0;
    int           n_errors = 0;
    bit           mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: pops expected data on each DUT pop, and checks state against the model
    always @(negedge clock) begin
        if (mon_en) begin
            if (read && !empty && !flush && !reset) begin
                if (exp_q.size() == 0) begin
                    chk("pop_unexpected", 32'(data_out), 32'hFFFF_FFFF);
                end else begin
                    chk("pop_data", 32'(data_out), 32'(exp_q.pop_front()));
                end
            end
            chk("count", 32'(count), 32'(mq.size()));
            chk("empty", 32'(empty), 32'(mq.size() == 0));
            chk("full", 32'(full), 32'(mq.size() == LEN));
            chk("almost_full", 32'(almost_full), 32'(mq.size() >= AF));
            chk("almost_empty", 32'(almost_empty), 32'(mq.size() <= AE));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("underflow", 32'(underflow), 32'(m_udf));
            chk("data_out", 32'(data_out), (mq.size() == 0) ? 32'h0 : 32'(mq[0]));
        end
    end

    // driver: one clock cycle with the given inputs, then the model advances
    task automatic cycle(input logic w, input logic r, input logic [W-1:0] d,
                         input logic f = 1'b0, input logic c = 1'b0, input logic rs = 1'b0);
        bit rd_ok, wr_ok;
        write = w; read = r; data_in = d; flush = f; clear_err = c; reset = rs;
        rd_ok = !rs && !f && r && (mq.size() > 0);
        wr_ok = !rs && !f && w && ((mq.size() < LEN) || rd_ok);
        if (rd_ok) exp_q.push_back(mq[0]);
        @(posedge clock);
        if (rs) begin
            mq.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            m_ovf = (m_ovf && !c) || (!f && w && !wr_ok);
            m_udf = (m_udf && !c) || (!f && r && !rd_ok);
            if (f) begin
                mq.delete();
            end else begin
                if (rd_ok) void'(mq.pop_front());
                if (wr_ok) mq.push_back(d);
            end
        end
        #1;
        if (mon_en) begin
            chk("exp_q_drained", 32'(exp_q.size()), 32'h0);
        end
        exp_q.delete();
    endtask

    initial begin
        reset = 1'b1; write = 1'b0; read = 1'b0; flush = 1'b0;
        clear_err = 1'b0; data_in = '0;
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        mon_en = 1'b1;
        cycle(1'b0, 1'b0, '0);

        // fill with 0x001..0x010 to full
        for (int i = 1; i <= LEN; i++) cycle(1'b1, 1'b0, W'(i));
        // overflow on a lone write at full, then clear it
        cycle(1'b1, 1'b0, 11'h555);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
        // simultaneous read+write at full
        cycle(1'b1, 1'b1, 11'h7FF);
        // drain everything
        for (int i = 0; i < LEN; i++) cycle(1'b0, 1'b1, '0);
        cycle(1'b0, 1'b0, '0);
        // read+write on empty
        cycle(1'b1, 1'b1, 11'h2A5);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, '0);
        // flush at count 9 with a concurrent write
        for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, W'($urandom_range(0, 2047)));
        cycle(1'b1, 1'b1, 11'h3C3, 1'b1);
        cycle(1'b1, 1'b0, 11'h123);
        cycle(1'b0, 1'b1, '0);
        // reset mid-stream at count 5 with read asserted
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, W'($urandom_range(0, 2047)));
        cycle(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 11'h155);
        cycle(1'b0, 1'b1, '0);
        cycle(1'b0, 1'b1, '0);

        // randomized traffic in phases with different write bias
        for (int p = 0; p < 8; p++) begin
            int wp;
            wp = (p % 2 == 0) ? 75 : 30;
            for (int i = 0; i < 200; i++) begin
                cycle($urandom_range(0, 99) < wp,
                      $urandom_range(0, 99) < 50,
                      W'($urandom_range(0, 2047)),
                      $urandom_range(0, 199) == 0,
                      $urandom_range(0, 29) == 0,
                      $urandom_range(0, 399) == 0);
            end
        end

        cycle(1'b0, 1'b0, '0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
